// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - result queue driving the register file write port with a pending-write scoreboard
// Optional macro WB_FWD_EN: bypass the value on the write port to rs1_fwd/rs2_fwd and drop busy on a hit.
module writeback_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    input  logic [4:0]                   issue_rd,
    output logic                         issue_stall,
    input  logic                         res_valid,
    output logic                         res_ready,
    input  logic [4:0]                   res_rd,
    input  logic [XLEN-1:0]              res_data,
    input  logic                         wr_hold,
    output logic [4:0]                   a3,
    output logic                         we3,
    output logic [XLEN-1:0]              wd3,
    input  logic [4:0]                   rs1,
    input  logic [4:0]                   rs2,
    output logic                         rs1_busy,
    output logic                         rs2_busy,
    output logic [XLEN-1:0]              rs1_fwd,
    output logic [XLEN-1:0]              rs2_fwd,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]     pending;
    logic [31:0]     pend_next;
    logic [4:0]      q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [CW-1:0]   cnt;
    logic            push;
    logic            pop;
    logic            issue_set;

    assign count       = cnt;
    assign res_ready   = (cnt < CW'(DEPTH));
    assign we3         = (cnt != '0) && !wr_hold;
    assign a3          = (cnt != '0) ? q_rd[rptr]   : 5'd0;
    assign wd3         = (cnt != '0) ? q_data[rptr] : '0;
    assign issue_stall = issue_valid && (issue_rd != 5'd0) && pending[issue_rd];

    // rd=0 results are consumed by the handshake but never occupy a slot
    assign push      = res_valid && res_ready && (res_rd != 5'd0);
    assign pop       = we3;
    assign issue_set = issue_valid && !issue_stall && (issue_rd != 5'd0);

    always_comb begin
        pend_next = pending;
        if (pop)
            pend_next[a3] = 1'b0;
        if (issue_set)
            pend_next[issue_rd] = 1'b1;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
        end else begin
            pending <= pend_next;
            if (push) begin
                q_rd[wptr]   <= res_rd;
                q_data[wptr] <= res_data;
                wptr         <= wptr + PW'(1);
            end
            if (pop)
                rptr <= rptr + PW'(1);
            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !push)
                cnt <= cnt - CW'(1);
        end
    end

`ifdef WB_FWD_EN
    logic hit1;
    logic hit2;
    assign hit1     = we3 && (a3 == rs1) && (rs1 != 5'd0);
    assign hit2     = we3 && (a3 == rs2) && (rs2 != 5'd0);
    assign rs1_busy = (rs1 != 5'd0) && pending[rs1] && !hit1;
    assign rs2_busy = (rs2 != 5'd0) && pending[rs2] && !hit2;
    assign rs1_fwd  = hit1 ? wd3 : '0;
    assign rs2_fwd  = hit2 ? wd3 : '0;
`else
    assign rs1_busy = (rs1 != 5'd0) && pending[rs1];
    assign rs2_busy = (rs2 != 5'd0) && pending[rs2];
    assign rs1_fwd  = '0;
    assign rs2_fwd  = '0;
`endif

endmodule
